// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES key-schedule types, round counts and helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128 = 2'b00,
        MODE_192 = 2'b01,
        MODE_256 = 2'b10,
        MODE_ILL = 2'b11
    } aes_mode_t;

    typedef logic [127:0] rkey_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of_mode(input aes_mode_t m);
        case (m)
            MODE_128: return NR_128;
            MODE_192: return NR_192;
            MODE_256: return NR_256;
            default:  return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_roundkey.sv
`default_nettype none
// ============================================================================
//  Module      : aes_roundkey
//  Description : Combinational single-step round-key generator.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_roundkey
    import aes_pkg::*;
(
    input  logic [3:0] rd,
    input  logic [1:0] mode,
    input  rkey_t      prev_key,
    input  rkey_t      current_key,
    output rkey_t      new_key
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i < 15; i++) begin
            if (i <= int'(n)) r = xtime(r);
        end
        return r;
    endfunction

    logic        w_is_256;
    logic [31:0] w_last;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [7:0]  w_rc;
    rkey_t       w_base;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    // AES-256 odd rounds use SubWord only; their base is the key two rounds back
    always_comb begin
        w_is_256 = (aes_mode_t'(mode) == MODE_256);
        w_last   = current_key[31:0];
        w_rot    = (w_is_256 && rd[0]) ? w_last : {w_last[23:0], w_last[31:24]};
        w_sub    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_rc     = w_is_256 ? (rd[0] ? 8'h00 : rcon(rd >> 1)) : rcon(rd);
        w_temp   = w_sub ^ {w_rc, 24'h000000};
        w_base   = w_is_256 ? prev_key : current_key;
        w_n0     = w_base[127:96] ^ w_temp;
        w_n1     = w_base[95:64]  ^ w_n0;
        w_n2     = w_base[63:32]  ^ w_n1;
        w_n3     = w_base[31:0]   ^ w_n2;
        new_key  = {w_n0, w_n1, w_n2, w_n3};
    end

endmodule
`default_nettype wire

// File: rtl/aes_keysched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_keysched_ctrl
//  Description : Iterative AES key expansion into a registered round-key store.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_keysched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_KEYS    = 15,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         mode_err,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    aes_mode_t  mode_q, mode_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    rkey_t      prev_q, prev_d;
    rkey_t      cur_q, cur_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       mode_err_q, mode_err_d;
    rkey_t      rd_key_q, rd_key_d;
    rkey_t      store_q [NUM_KEYS];
    rkey_t      store_d [NUM_KEYS];
    rkey_t      w_new_key;
    logic       w_is_256;

    aes_roundkey u_roundkey (
        .rd          (rd_cnt_q),
        .mode        (mode_q),
        .prev_key    (prev_q),
        .current_key (cur_q),
        .new_key     (w_new_key)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        nr_d       = nr_q;
        rd_cnt_d   = rd_cnt_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mode_err_d = 1'b0;
        store_d    = store_q;
        w_is_256   = (aes_mode_t'(mode) == MODE_256);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && (aes_mode_t'(mode) == MODE_ILL)) begin
                    mode_err_d = 1'b1;
                end else if (start) begin
                    mode_d     = aes_mode_t'(mode);
                    nr_d       = nr_of_mode(aes_mode_t'(mode));
                    store_d[0] = key_in[255:128];
                    if (w_is_256) store_d[1] = key_in[127:0];
                    prev_d     = key_in[255:128];
                    cur_d      = w_is_256 ? key_in[127:0] : key_in[255:128];
                    rd_cnt_d   = w_is_256 ? 4'd2 : 4'd1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                store_d[rd_cnt_q] = w_new_key;
                prev_d            = (mode_q == MODE_256) ? cur_q : w_new_key;
                cur_d             = w_new_key;
                rd_cnt_d          = rd_cnt_q + 4'd1;
                if (rd_cnt_q == nr_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entries beyond the latched Nr may hold keys of an earlier, longer run
        rd_key_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (int'(rd_idx) == i) rd_key_d = store_q[i];
        end
        if (ZERO_UNUSED && (rd_idx > nr_q)) rd_key_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_128;
            nr_q       <= 4'd0;
            rd_cnt_q   <= 4'd0;
            prev_q     <= '0;
            cur_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_err_q <= 1'b0;
            rd_key_q   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) store_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            nr_q       <= nr_d;
            rd_cnt_q   <= rd_cnt_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mode_err_q <= mode_err_d;
            rd_key_q   <= rd_key_d;
            store_q    <= store_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mode_err   = mode_err_q;
    assign num_rounds = nr_q;
    assign rd_key     = rd_key_q;

endmodule
`default_nettype wire
